// File: rtl/bcd_counter_n.sv
// Multi-digit cascaded BCD up/down counter with clear, checked parallel load,
// wrap/saturate at terminal count and a combinational ripple enable for chaining.
module bcd_counter_n #(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_in,
    input  logic                  upd,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   ld_val,
    output logic [4*DIGITS-1:0]   op,
    output logic                  en_out,
    output logic                  wrap,
    output logic                  ld_err
);

    logic [4*DIGITS-1:0] op_q, op_d, cnt_next;
    logic                wrap_q, wrap_d;
    logic                ld_err_q, ld_err_d;
    logic                all_nine, all_zero, ld_ok, at_term;

    // Per-digit step with a ripple carry/borrow; a digit moves only while every
    // lower digit sits at its roll-over value for the current direction.
    always_comb begin : digit_chain
        logic       chain;
        logic [3:0] dig;
        all_nine = 1'b1;
        all_zero = 1'b1;
        ld_ok    = 1'b1;
        chain    = 1'b1;
        dig      = '0;
        cnt_next = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            dig = op_q[4*k +: 4];
            if (dig != 4'd9) all_nine = 1'b0;
            if (dig != 4'd0) all_zero = 1'b0;
            if (ld_val[4*k +: 4] > 4'd9) ld_ok = 1'b0;
            if (!chain)
                cnt_next[4*k +: 4] = dig;
            else if (upd)
                cnt_next[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            else
                cnt_next[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            chain = chain & (upd ? (dig == 4'd9) : (dig == 4'd0));
        end
    end

    assign at_term = upd ? all_nine : all_zero;

    always_comb begin : next_state
        op_d     = op_q;
        wrap_d   = 1'b0;
        ld_err_d = 1'b0;
        if (clr) begin
            op_d = '0;
        end else if (ld) begin
            if (ld_ok) op_d     = ld_val;
            else       ld_err_d = 1'b1;
        end else if (en_in) begin
            if (!at_term) begin
                op_d = cnt_next;
            end else if (!SATURATE) begin
                op_d   = cnt_next;
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            op_q     <= op_d;
            wrap_q   <= wrap_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign op     = op_q;
    assign wrap   = wrap_q;
    assign ld_err = ld_err_q;
    assign en_out = en_in & at_term;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Randomised and directed checks of bcd_counter_n against a decimal-integer model.
module tb_bcd_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, upd, clr, ld;
    logic [15:0] ld_val;
    logic [7:0]  op_w, op_s;
    logic [15:0] op_4;
    logic        eo_w, eo_s, eo_4, wr_w, wr_s, wr_4, le_w, le_s, le_4;

    logic        c_en, c_upd, c_clr, c_ld;
    logic [7:0]  c_ld_val;
    logic [3:0]  op_lo, op_hi;
    logic        eo_lo, eo_hi, wr_lo, wr_hi, le_lo, le_hi;

    int total = 0;
    int bad   = 0;

    int m_w, m_s, m_4;
    bit mw_w, mw_s, mw_4, me_w, me_s, me_4;

    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en_in(en), .upd(upd), .clr(clr), .ld(ld),
        .ld_val(ld_val[7:0]), .op(op_w), .en_out(eo_w), .wrap(wr_w), .ld_err(le_w));
    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en_in(en), .upd(upd), .clr(clr), .ld(ld),
        .ld_val(ld_val[7:0]), .op(op_s), .en_out(eo_s), .wrap(wr_s), .ld_err(le_s));
    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) u_four (
        .clk(clk), .rst(rst), .en_in(en), .upd(upd), .clr(clr), .ld(ld),
        .ld_val(ld_val), .op(op_4), .en_out(eo_4), .wrap(wr_4), .ld_err(le_4));
    bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_lo (
        .clk(clk), .rst(rst), .en_in(c_en), .upd(c_upd), .clr(c_clr), .ld(c_ld),
        .ld_val(c_ld_val[3:0]), .op(op_lo), .en_out(eo_lo), .wrap(wr_lo), .ld_err(le_lo));
    bcd_counter_n #(.DIGITS(1), .SATURATE(1'b0)) u_hi (
        .clk(clk), .rst(rst), .en_in(eo_lo), .upd(c_upd), .clr(c_clr), .ld(c_ld),
        .ld_val(c_ld_val[7:4]), .op(op_hi), .en_out(eo_hi), .wrap(wr_hi), .ld_err(le_hi));

    function automatic logic [31:0] to_bcd(input int v);
        int x = v;
        logic [31:0] r = '0;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [31:0] x, input int nd, output bit badd);
        int v = 0;
        int p = 1;
        logic [3:0] d;
        badd = 1'b0;
        for (int k = 0; k < nd; k++) begin
            d = x[4*k +: 4];
            if (d > 4'd9) badd = 1'b1;
            v = v + int'(d) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic int max_of(input int nd);
        int m = 1;
        for (int k = 0; k < nd; k++) m = m * 10;
        return m - 1;
    endfunction

    function automatic bit exp_eo(input int v, input int nd);
        return en & (upd ? (v == max_of(nd)) : (v == 0));
    endfunction

    task automatic model_step(inout int v, input int nd, input bit sat, output bit w, output bit e);
        bit b;
        int lv;
        int mx = max_of(nd);
        w = 1'b0;
        e = 1'b0;
        if (!rst)     v = 0;
        else if (clr) v = 0;
        else if (ld) begin
            lv = from_bcd({16'h0, ld_val}, nd, b);
            if (b) e = 1'b1;
            else   v = lv;
        end else if (en) begin
            if (upd) begin
                if (v != mx)  v = v + 1;
                else if (!sat) begin v = 0; w = 1'b1; end
            end else begin
                if (v != 0)   v = v - 1;
                else if (!sat) begin v = mx; w = 1'b1; end
            end
        end
    endtask

    task automatic tick();
        model_step(m_w, 2, 1'b0, mw_w, me_w);
        model_step(m_s, 2, 1'b1, mw_s, me_s);
        model_step(m_4, 4, 1'b0, mw_4, me_4);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        m_w = 0; m_s = 0; m_4 = 0;
        mw_w = 0; mw_s = 0; mw_4 = 0; me_w = 0; me_s = 0; me_4 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; upd = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = '0;
        c_en = 1'b0; c_upd = 1'b1; c_clr = 1'b0; c_ld = 1'b0; c_ld_val = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        total++; if (op_w !== 8'h00) begin bad++; $display("FAIL reset_op_w got=%h exp=00", op_w); end
        total++; if (op_4 !== 16'h0000) begin bad++; $display("FAIL reset_op_4 got=%h exp=0000", op_4); end
        total++; if ({wr_w, le_w, wr_4, le_4} !== 4'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {wr_w, le_w, wr_4, le_4}); end
        total++; if (eo_w !== 1'b0) begin bad++; $display("FAIL reset_eo_off got=%b exp=0", eo_w); end
        en = 1'b1; upd = 1'b0; #1;
        total++; if (eo_w !== 1'b1) begin bad++; $display("FAIL reset_eo_down got=%b exp=1", eo_w); end
        upd = 1'b1; #1;
        total++; if (eo_w !== 1'b0) begin bad++; $display("FAIL reset_eo_up got=%b exp=0", eo_w); end
    endtask

    task automatic test_count_up();
        logic [31:0] e;
        rst = 1'b1; en = 1'b1; upd = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            e = to_bcd(i);
            total++; if (op_w !== e[7:0]) begin bad++; $display("FAIL count_up step=%0d got=%h exp=%h", i, op_w, e[7:0]); end
            total++; if (wr_w !== 1'b0) begin bad++; $display("FAIL count_up_wrap step=%0d got=%b exp=0", i, wr_w); end
        end
        total++; if (op_4 !== 16'h0012) begin bad++; $display("FAIL count_up_4 got=%h exp=0012", op_4); end
    endtask

    task automatic test_wrap();
        en = 1'b0; ld = 1'b1; ld_val = 16'h0098;
        tick();
        ld = 1'b0;
        total++; if (op_w !== 8'h98) begin bad++; $display("FAIL wrap_load got=%h exp=98", op_w); end
        en = 1'b1; upd = 1'b1;
        tick();
        total++; if (op_w !== 8'h99) begin bad++; $display("FAIL wrap_99 got=%h exp=99", op_w); end
        total++; if (eo_w !== 1'b1) begin bad++; $display("FAIL wrap_eo got=%b exp=1", eo_w); end
        tick();
        total++; if (op_w !== 8'h00 || wr_w !== 1'b1) begin bad++; $display("FAIL wrap_roll got=%h/%b exp=00/1", op_w, wr_w); end
        total++; if (op_s !== 8'h99 || wr_s !== 1'b0) begin bad++; $display("FAIL wrap_sat_hold got=%h/%b exp=99/0", op_s, wr_s); end
        tick();
        total++; if (op_w !== 8'h01 || wr_w !== 1'b0) begin bad++; $display("FAIL wrap_after got=%h/%b exp=01/0", op_w, wr_w); end
        total++; if (op_4 !== 16'h0101) begin bad++; $display("FAIL wrap_4 got=%h exp=0101", op_4); end
    endtask

    task automatic test_saturate();
        logic [31:0] e;
        en = 1'b0; ld = 1'b1; ld_val = 16'h0001;
        tick();
        ld = 1'b0; en = 1'b1; upd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (op_s !== 8'h00 || wr_s !== 1'b0) begin bad++; $display("FAIL sat_hold step=%0d got=%h/%b exp=00/0", i, op_s, wr_s); end
            total++; if (eo_s !== 1'b1) begin bad++; $display("FAIL sat_eo step=%0d got=%b exp=1", i, eo_s); end
            e = to_bcd(m_w);
            total++; if (op_w !== e[7:0] || wr_w !== mw_w) begin bad++; $display("FAIL sat_wrapinst step=%0d got=%h/%b exp=%h/%b", i, op_w, wr_w, e[7:0], mw_w); end
        end
    endtask

    task automatic test_load_err();
        en = 1'b0; ld = 1'b1; ld_val = 16'h0027;
        tick();
        total++; if (op_w !== 8'h27) begin bad++; $display("FAIL lderr_setup got=%h exp=27", op_w); end
        ld_val = 16'h003A; en = 1'b1;
        tick();
        total++; if (op_w !== 8'h27 || le_w !== 1'b1) begin bad++; $display("FAIL lderr_reject got=%h/%b exp=27/1", op_w, le_w); end
        total++; if (le_4 !== 1'b1) begin bad++; $display("FAIL lderr_reject_4 got=%b exp=1", le_4); end
        ld_val = 16'h0045;
        tick();
        total++; if (op_w !== 8'h45 || le_w !== 1'b0) begin bad++; $display("FAIL lderr_good got=%h/%b exp=45/0", op_w, le_w); end
        ld_val = 16'h00F0;
        tick();
        total++; if (le_w !== 1'b1) begin bad++; $display("FAIL lderr_b2b_1 got=%b exp=1", le_w); end
        ld_val = 16'h00A5;
        tick();
        total++; if (le_w !== 1'b1 || op_w !== 8'h45) begin bad++; $display("FAIL lderr_b2b_2 got=%b/%h exp=1/45", le_w, op_w); end
        ld = 1'b0; en = 1'b0;
        tick();
        total++; if (le_w !== 1'b0) begin bad++; $display("FAIL lderr_end got=%b exp=0", le_w); end
    endtask

    task automatic test_clr_priority();
        en = 1'b0; ld = 1'b1; ld_val = 16'h0055;
        tick();
        clr = 1'b1; ld = 1'b1; en = 1'b1; ld_val = 16'h0099;
        tick();
        total++; if (op_w !== 8'h00 || wr_w !== 1'b0 || le_w !== 1'b0) begin bad++; $display("FAIL clr_prio got=%h/%b/%b exp=00/0/0", op_w, wr_w, le_w); end
        clr = 1'b0; en = 1'b0; ld_val = 16'h0007;
        tick();
        total++; if (op_w !== 8'h07) begin bad++; $display("FAIL clr_load7 got=%h exp=07", op_w); end
        ld = 1'b0;
        #2 rst = 1'b0;
        #1;
        clear_model();
        total++; if (op_w !== 8'h00 || op_4 !== 16'h0000) begin bad++; $display("FAIL async_rst got=%h/%h exp=00/0000", op_w, op_4); end
        rst = 1'b1; ld = 1'b1; ld_val = 16'h0099;
        tick();
        ld = 1'b0; en = 1'b1; upd = 1'b1;
        tick();
        total++; if (wr_w !== 1'b1) begin bad++; $display("FAIL midpulse_pre got=%b exp=1", wr_w); end
        #2 rst = 1'b0;
        #1;
        clear_model();
        total++; if (wr_w !== 1'b0 || op_w !== 8'h00) begin bad++; $display("FAIL midpulse_rst got=%b/%h exp=0/00", wr_w, op_w); end
        rst = 1'b1;
        tick();
        total++; if (op_w !== 8'h01) begin bad++; $display("FAIL resume got=%h exp=01", op_w); end
        en = 1'b0;
    endtask

    task automatic test_cascade();
        logic [31:0] e;
        c_clr = 1'b0; c_ld = 1'b1; c_ld_val = 8'h00; c_en = 1'b0;
        tick();
        c_ld = 1'b0; c_en = 1'b1; c_upd = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            e = to_bcd(i);
            total++; if ({op_hi, op_lo} !== e[7:0]) begin bad++; $display("FAIL cascade_up step=%0d got=%h exp=%h", i, {op_hi, op_lo}, e[7:0]); end
        end
        total++; if ({wr_lo, wr_hi, le_lo, le_hi} !== 4'b0) begin bad++; $display("FAIL cascade_pulses got=%b exp=0000", {wr_lo, wr_hi, le_lo, le_hi}); end
        c_en = 1'b0; c_ld = 1'b1; c_ld_val = 8'h10;
        tick();
        c_ld = 1'b0; c_en = 1'b1; c_upd = 1'b0; #1;
        total++; if (eo_lo !== 1'b1 || eo_hi !== 1'b0) begin bad++; $display("FAIL cascade_eo got=%b%b exp=10", eo_lo, eo_hi); end
        tick();
        total++; if ({op_hi, op_lo} !== 8'h09) begin bad++; $display("FAIL cascade_down got=%h exp=09", {op_hi, op_lo}); end
        c_en = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic [15:0] picks [4];
        picks[0] = 16'h9998; picks[1] = 16'h0001; picks[2] = 16'h9999; picks[3] = 16'h0000;
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom_range(0, 19) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            upd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ld_val = 16'($urandom);
                1:       ld_val = 16'(to_bcd(int'($urandom_range(0, 9999))));
                default: ld_val = picks[$urandom_range(0, 3)];
            endcase
            #1;
            total++; if ({eo_w, eo_s, eo_4} !== {exp_eo(m_w, 2), exp_eo(m_s, 2), exp_eo(m_4, 4)})
                begin bad++; $display("FAIL rnd_eo n=%0d got=%b exp=%b", n, {eo_w, eo_s, eo_4}, {exp_eo(m_w, 2), exp_eo(m_s, 2), exp_eo(m_4, 4)}); end
            tick();
            e = to_bcd(m_w);
            total++; if (op_w !== e[7:0] || wr_w !== mw_w || le_w !== me_w) begin bad++; $display("FAIL rnd_wrapinst n=%0d got=%h/%b/%b exp=%h/%b/%b", n, op_w, wr_w, le_w, e[7:0], mw_w, me_w); end
            e = to_bcd(m_s);
            total++; if (op_s !== e[7:0] || wr_s !== mw_s || le_s !== me_s) begin bad++; $display("FAIL rnd_satinst n=%0d got=%h/%b/%b exp=%h/%b/%b", n, op_s, wr_s, le_s, e[7:0], mw_s, me_s); end
            e = to_bcd(m_4);
            total++; if (op_4 !== e[15:0] || wr_4 !== mw_4 || le_4 !== me_4) begin bad++; $display("FAIL rnd_fourinst n=%0d got=%h/%b/%b exp=%h/%b/%b", n, op_4, wr_4, le_4, e[15:0], mw_4, me_4); end
        end
        clr = 1'b0; ld = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate();
        test_load_err();
        test_clr_priority();
        test_cascade();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
